// File: rtl/jtkcpu_busif_pkg.sv
// Shared state encodings and byte/word widths for the jtkcpu operand bus interface.
`default_nettype none

package jtkcpu_busif_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/jtkcpu_busif.sv
// jtkcpu_busif: moves 8/16-bit big-endian operands between the ALU datapath and an 8-bit bus.
// Optional bus-wait timeout enabled by defining JTKCPU_BUSIF_TOUT_EN.
`default_nettype none

module jtkcpu_busif
    import jtkcpu_busif_pkg::*;
#(
    parameter int TOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen,
    input  logic                req,
    input  logic                wr,
    input  logic                w16,
    input  logic [WORD_W-1:0]   addr,
    input  logic [WORD_W-1:0]   wdata,
    output logic [WORD_W-1:0]   rdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [WORD_W-1:0]   bus_addr,
    output logic [BYTE_W-1:0]   bus_dout,
    input  logic [BYTE_W-1:0]   bus_din,
    output logic                bus_rd,
    output logic                bus_we,
    input  logic                bus_wait
);

    state_t              state;
    logic                wr_q;
    logic                w16_q;
    logic [BYTE_W-1:0]   wlo_q;

    assign busy = (state != ST_IDLE);

`ifdef JTKCPU_BUSIF_TOUT_EN
    logic [TOUT_W-1:0] tout_cnt;
    // Abort on the wait edge that would bring the counter to all-ones.
    localparam logic [TOUT_W-1:0] TOUT_LAST = {{(TOUT_W-1){1'b1}}, 1'b0};
`else
    if (TOUT_W > 0) begin : g_tout_unused
    end
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_q     <= 1'b0;
            w16_q    <= 1'b0;
            wlo_q    <= '0;
            rdata    <= '0;
            done     <= 1'b0;
            bus_addr <= '0;
            bus_dout <= '0;
            bus_rd   <= 1'b0;
            bus_we   <= 1'b0;
`ifdef JTKCPU_BUSIF_TOUT_EN
            tout_cnt <= '0;
            err      <= 1'b0;
`endif
        end else if (cen) begin
            done <= 1'b0;
`ifdef JTKCPU_BUSIF_TOUT_EN
            err  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        wr_q     <= wr;
                        w16_q    <= w16;
                        wlo_q    <= wdata[BYTE_W-1:0];
                        bus_addr <= addr;
                        bus_dout <= w16 ? wdata[WORD_W-1:BYTE_W] : wdata[BYTE_W-1:0];
                        bus_rd   <= ~wr;
                        bus_we   <= wr;
                        state    <= w16 ? ST_HI : ST_LO;
                    end
                end
                ST_HI: begin
                    if (!bus_wait) begin
                        if (!wr_q) rdata[WORD_W-1:BYTE_W] <= bus_din;
                        bus_addr <= bus_addr + 16'd1;
                        bus_dout <= wlo_q;
                        state    <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (!bus_wait) begin
                        if (!wr_q) begin
                            rdata[BYTE_W-1:0] <= bus_din;
                            if (!w16_q) rdata[WORD_W-1:BYTE_W] <= '0;
                        end
                        done   <= 1'b1;
                        bus_rd <= 1'b0;
                        bus_we <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    bus_rd <= 1'b0;
                    bus_we <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
`ifdef JTKCPU_BUSIF_TOUT_EN
            if (state != ST_IDLE) begin
                if (!bus_wait) begin
                    tout_cnt <= '0;
                end else if (tout_cnt == TOUT_LAST) begin
                    tout_cnt <= '0;
                    err      <= 1'b1;
                    bus_rd   <= 1'b0;
                    bus_we   <= 1'b0;
                    state    <= ST_IDLE;
                end else begin
                    tout_cnt <= tout_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtkcpu_busif.sv
// Directed self-checking bench for jtkcpu_busif with a 64 KiB byte-memory bus model.
`default_nettype none

module tb_jtkcpu_busif;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        req;
    logic        wr;
    logic        w16;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] bus_addr;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        bus_rd;
    logic        bus_we;
    logic        bus_wait;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:65535];

    jtkcpu_busif #(.TOUT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .req(req), .wr(wr), .w16(w16),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
        .err(err), .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
        .bus_rd(bus_rd), .bus_we(bus_we), .bus_wait(bus_wait)
    );

    always #5 clk = ~clk;

    assign bus_din = mem[bus_addr];

    always @(posedge clk) begin
        if (cen && bus_we && !bus_wait) mem[bus_addr] <= bus_dout;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic wide, input logic [15:0] a, input logic [15:0] d);
        req = 1'b1; wr = w; w16 = wide; addr = a; wdata = d;
        tick();
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cen = 1'b1; req = 1'b0; wr = 1'b0; w16 = 1'b0;
        addr = 16'h0; wdata = 16'h0; bus_wait = 1'b0;
        repeat (3) tick();
        total++;
        if ({rdata, busy, done, err, bus_addr, bus_dout, bus_rd, bus_we} !== 45'h0) begin
            bad++;
            $display("FAIL reset_outputs rdata=%h busy=%b done=%b err=%b addr=%h dout=%h rd=%b we=%b expected all zero",
                     rdata, busy, done, err, bus_addr, bus_dout, bus_rd, bus_we);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read8();
        mem[16'h1234] = 8'h5A;
        start(1'b0, 1'b0, 16'h1234, 16'h0);
        total++;
        if ({bus_addr, bus_rd, bus_we, busy, done} !== {16'h1234, 4'b1010}) begin
            bad++;
            $display("FAIL read8_strobe addr=%h rd=%b we=%b busy=%b done=%b expected 1234 1 0 1 0",
                     bus_addr, bus_rd, bus_we, busy, done);
        end
        tick();
        total++;
        if ({rdata, done, busy, bus_rd} !== {16'h005A, 3'b100}) begin
            bad++;
            $display("FAIL read8_done rdata=%h done=%b busy=%b rd=%b expected 005A 1 0 0", rdata, done, busy, bus_rd);
        end
        tick();
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL read8_done_pulse done=%b expected 0", done);
        end
    endtask

    task automatic test_read16_wrap();
        mem[16'hFFFF] = 8'h12; mem[16'h0000] = 8'h34;
        start(1'b0, 1'b1, 16'hFFFF, 16'h0);
        total++;
        if ({bus_addr, bus_rd} !== {16'hFFFF, 1'b1}) begin
            bad++;
            $display("FAIL read16_hi addr=%h rd=%b expected FFFF 1", bus_addr, bus_rd);
        end
        tick();
        total++;
        if ({bus_addr, bus_rd, done} !== {16'h0000, 2'b10}) begin
            bad++;
            $display("FAIL read16_lo_wrap addr=%h rd=%b done=%b expected 0000 1 0", bus_addr, bus_rd, done);
        end
        tick();
        total++;
        if ({rdata, done} !== {16'h1234, 1'b1}) begin
            bad++;
            $display("FAIL read16_data rdata=%h done=%b expected 1234 1", rdata, done);
        end
    endtask

    task automatic test_write16();
        mem[16'h2000] = 8'h00; mem[16'h2001] = 8'h00;
        start(1'b1, 1'b1, 16'h2000, 16'hBEEF);
        total++;
        if ({bus_addr, bus_dout, bus_we, bus_rd} !== {16'h2000, 8'hBE, 2'b10}) begin
            bad++;
            $display("FAIL write16_hi addr=%h dout=%h we=%b rd=%b expected 2000 BE 1 0", bus_addr, bus_dout, bus_we, bus_rd);
        end
        tick();
        total++;
        if ({bus_addr, bus_dout, bus_we} !== {16'h2001, 8'hEF, 1'b1}) begin
            bad++;
            $display("FAIL write16_lo addr=%h dout=%h we=%b expected 2001 EF 1", bus_addr, bus_dout, bus_we);
        end
        tick();
        total++;
        if ({mem[16'h2000], mem[16'h2001], rdata, done, bus_we} !== {8'hBE, 8'hEF, 16'h1234, 2'b10}) begin
            bad++;
            $display("FAIL write16_result m2000=%h m2001=%h rdata=%h done=%b we=%b expected BE EF 1234 1 0",
                     mem[16'h2000], mem[16'h2001], rdata, done, bus_we);
        end
    endtask

    task automatic test_wait();
        mem[16'h4000] = 8'hAB; mem[16'h4001] = 8'hCD;
        bus_wait = 1'b1;
        start(1'b0, 1'b1, 16'h4000, 16'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({bus_addr, bus_rd, busy, done} !== {16'h4000, 3'b110}) begin
                bad++;
                $display("FAIL wait_hold_%0d addr=%h rd=%b busy=%b done=%b expected 4000 1 1 0", i, bus_addr, bus_rd, busy, done);
            end
        end
        bus_wait = 1'b0;
        tick();
        tick();
        total++;
        if ({rdata, done} !== {16'hABCD, 1'b1}) begin
            bad++;
            $display("FAIL wait_data rdata=%h done=%b expected ABCD 1", rdata, done);
        end
    endtask

    task automatic test_cen_hold();
        mem[16'h0010] = 8'h77;
        start(1'b0, 1'b0, 16'h0010, 16'h0);
        cen = 1'b0;
        tick(); tick();
        total++;
        if ({busy, done, bus_rd, rdata} !== {3'b101, 16'hABCD}) begin
            bad++;
            $display("FAIL cen_hold busy=%b done=%b rd=%b rdata=%h expected 1 0 1 ABCD", busy, done, bus_rd, rdata);
        end
        cen = 1'b1;
        tick();
        total++;
        if ({rdata, done} !== {16'h0077, 1'b1}) begin
            bad++;
            $display("FAIL cen_read8_zext rdata=%h done=%b expected 0077 1", rdata, done);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        mem[16'h4001] = 8'hCD;
        req = 1'b1; wr = 1'b0; w16 = 1'b0; addr = 16'h1234;
        tick();
        addr = 16'h4001;
        tick();
        total++;
        if ({rdata, done, busy} !== {16'h005A, 2'b10}) begin
            bad++;
            $display("FAIL b2b_first rdata=%h done=%b busy=%b expected 005A 1 0", rdata, done, busy);
        end
        tick();
        req = 1'b0;
        total++;
        if ({bus_addr, busy, done} !== {16'h4001, 2'b10}) begin
            bad++;
            $display("FAIL b2b_accept addr=%h busy=%b done=%b expected 4001 1 0", bus_addr, busy, done);
        end
        tick();
        total++;
        if ({rdata, done} !== {16'h00CD, 1'b1}) begin
            bad++;
            $display("FAIL b2b_second rdata=%h done=%b expected 00CD 1", rdata, done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        start(1'b1, 1'b1, 16'h3000, 16'h1122);
        tick();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus_we, bus_rd, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_mid we=%b rd=%b busy=%b done=%b expected 0 0 0 0", bus_we, bus_rd, busy, done);
        end
        @(negedge clk); rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0 || mem[16'h3001] === 8'h22) begin
            bad++;
            $display("FAIL reset_mid_no_done saw_done=%b m3001=%h expected 0 and no low byte write", saw_done, mem[16'h3001]);
        end
    endtask

`ifdef JTKCPU_BUSIF_TOUT_EN
    task automatic test_timeout();
        bus_wait = 1'b1;
        start(1'b0, 1'b0, 16'h0010, 16'h0);
        for (int i = 1; i < 15; i++) tick();
        total++;
        if ({err, busy} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_early err=%b busy=%b expected 0 1", err, busy);
        end
        tick();
        total++;
        if ({err, busy, done, bus_rd, rdata} !== {4'b1000, 16'h00CD}) begin
            bad++;
            $display("FAIL timeout_abort err=%b busy=%b done=%b rd=%b rdata=%h expected 1 0 0 0 00CD",
                     err, busy, done, bus_rd, rdata);
        end
        tick();
        total++;
        if ({err, done} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_pulse err=%b done=%b expected 0 0", err, done);
        end
        bus_wait = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_read8();
        test_read16_wrap();
        test_write16();
        test_wait();
        test_cen_hold();
        test_back_to_back();
`ifdef JTKCPU_BUSIF_TOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
